// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage forwarding muxes for the 5-stage MIPS pipeline.
// Stalls refresh held operands so WB-forwarded values survive the producer retiring.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic          id_reg_write,
    input  logic          id_alu_src,
    input  logic [CW-1:0] id_ctrl,
    input  logic [4:0]    id_rs_addr,
    input  logic [4:0]    id_rt_addr,
    input  logic [4:0]    id_rd_addr,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [1:0]    fwd_a,
    input  logic [1:0]    fwd_b,
    input  logic [DW-1:0] mem_alu_result,
    input  logic [DW-1:0] wb_write_data,
    output logic          ex_valid,
    output logic          ex_reg_write,
    output logic          ex_alu_src,
    output logic [CW-1:0] ex_ctrl,
    output logic [4:0]    ex_rs_addr,
    output logic [4:0]    ex_rt_addr,
    output logic [4:0]    ex_rd_addr,
    output logic [DW-1:0] ex_imm,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [DW-1:0] ex_store_data,
    output logic [15:0]   bubble_cnt
);

    logic          valid_r;
    logic          reg_write_r;
    logic          alu_src_r;
    logic [CW-1:0] ctrl_r;
    logic [4:0]    rs_addr_r;
    logic [4:0]    rt_addr_r;
    logic [4:0]    rd_addr_r;
    logic [DW-1:0] rs_data_r;
    logic [DW-1:0] rt_data_r;
    logic [DW-1:0] imm_r;
    logic [15:0]   bubble_cnt_r;

    logic [DW-1:0] fwd_rs_s;
    logic [DW-1:0] fwd_rt_s;
    logic          bubble_inc_s;

    // 10 selects MEM, 01 selects WB; 00 and 11 both fall back to the stored register value.
    function automatic logic [DW-1:0] fwd_pick(input logic [1:0] sel,
                                               input logic [DW-1:0] stored,
                                               input logic [DW-1:0] mem_val,
                                               input logic [DW-1:0] wb_val);
        logic [DW-1:0] res;
        case (sel)
            2'b10:   res = mem_val;
            2'b01:   res = wb_val;
            default: res = stored;
        endcase
        return res;
    endfunction

    // Forward muxes and bubble detection.
    always_comb begin
        fwd_rs_s     = fwd_pick(fwd_a, rs_data_r, mem_alu_result, wb_write_data);
        fwd_rt_s     = fwd_pick(fwd_b, rt_data_r, mem_alu_result, wb_write_data);
        bubble_inc_s = flush | (~stall & ~id_valid);
    end

    // Pipeline register: reset > flush > stall (operand refresh) > load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            valid_r     <= 1'b0;
            reg_write_r <= 1'b0;
            alu_src_r   <= 1'b0;
            ctrl_r      <= {CW{1'b0}};
            rs_addr_r   <= 5'd0;
            rt_addr_r   <= 5'd0;
            rd_addr_r   <= 5'd0;
            rs_data_r   <= {DW{1'b0}};
            rt_data_r   <= {DW{1'b0}};
            imm_r       <= {DW{1'b0}};
        end else if (stall) begin
            rs_data_r <= fwd_rs_s;
            rt_data_r <= fwd_rt_s;
        end else begin
            valid_r     <= id_valid;
            reg_write_r <= id_reg_write & id_valid;
            alu_src_r   <= id_alu_src;
            ctrl_r      <= id_ctrl;
            rs_addr_r   <= id_rs_addr;
            rt_addr_r   <= id_rt_addr;
            rd_addr_r   <= id_rd_addr;
            rs_data_r   <= id_rs_data;
            rt_data_r   <= id_rt_data;
            imm_r       <= id_imm;
        end
    end

    // Saturating bubble counter; flush inserts a bubble but does not clear the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_r <= 16'd0;
        end else if (bubble_inc_s && (bubble_cnt_r != 16'hFFFF)) begin
            bubble_cnt_r <= bubble_cnt_r + 16'd1;
        end else begin
            bubble_cnt_r <= bubble_cnt_r;
        end
    end

    assign ex_valid      = valid_r;
    assign ex_reg_write  = reg_write_r;
    assign ex_alu_src    = alu_src_r;
    assign ex_ctrl       = ctrl_r;
    assign ex_rs_addr    = rs_addr_r;
    assign ex_rt_addr    = rt_addr_r;
    assign ex_rd_addr    = rd_addr_r;
    assign ex_imm        = imm_r;
    assign alu_a         = fwd_rs_s;
    assign ex_store_data = fwd_rt_s;
    assign alu_b         = alu_src_r ? imm_r : fwd_rt_s;
    assign bubble_cnt    = bubble_cnt_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed cases plus randomized traffic
// compared against a behavioural model of the EX-stage contents.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, id_valid, id_reg_write, id_alu_src;
    logic [7:0]  id_ctrl;
    logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] mem_alu_result, wb_write_data;
    logic        ex_valid, ex_reg_write, ex_alu_src;
    logic [7:0]  ex_ctrl;
    logic [4:0]  ex_rs_addr, ex_rt_addr, ex_rd_addr;
    logic [31:0] ex_imm, alu_a, alu_b, ex_store_data;
    logic [15:0] bubble_cnt;

    int checks = 0;
    int errors = 0;

    // Model of what the EX stage currently holds.
    logic        m_valid, m_rw, m_src;
    logic [7:0]  m_ctrl;
    logic [4:0]  m_rs_a, m_rt_a, m_rd_a;
    logic [31:0] m_rs, m_rt, m_imm;
    int          m_cnt;

    id_ex_stage #(.DW(32), .CW(8)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_reg_write(id_reg_write), .id_alu_src(id_alu_src), .id_ctrl(id_ctrl),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_alu_result(mem_alu_result),
        .wb_write_data(wb_write_data), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_alu_src(ex_alu_src), .ex_ctrl(ex_ctrl), .ex_rs_addr(ex_rs_addr),
        .ex_rt_addr(ex_rt_addr), .ex_rd_addr(ex_rd_addr), .ex_imm(ex_imm),
        .alu_a(alu_a), .alu_b(alu_b), .ex_store_data(ex_store_data), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] stored);
        if (sel == 2'b10) return mem_alu_result;
        if (sel == 2'b01) return wb_write_data;
        return stored;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_rw = 1'b0; m_src = 1'b0; m_ctrl = 8'd0;
        m_rs_a = 5'd0; m_rt_a = 5'd0; m_rd_a = 5'd0;
        m_rs = 32'd0; m_rt = 32'd0; m_imm = 32'd0; m_cnt = 0;
    endtask

    task automatic model_edge();
        logic [31:0] nrs, nrt;
        nrs = pick(fwd_a, m_rs);
        nrt = pick(fwd_b, m_rt);
        if (flush || (!stall && !id_valid)) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
        if (flush) begin
            m_valid = 1'b0; m_rw = 1'b0; m_src = 1'b0; m_ctrl = 8'd0;
            m_rs_a = 5'd0; m_rt_a = 5'd0; m_rd_a = 5'd0;
            m_rs = 32'd0; m_rt = 32'd0; m_imm = 32'd0;
        end else if (stall) begin
            m_rs = nrs; m_rt = nrt;
        end else begin
            m_valid = id_valid; m_rw = id_reg_write && id_valid; m_src = id_alu_src;
            m_ctrl = id_ctrl; m_rs_a = id_rs_addr; m_rt_a = id_rt_addr; m_rd_a = id_rd_addr;
            m_rs = id_rs_data; m_rt = id_rt_data; m_imm = id_imm;
        end
    endtask

    task automatic check_all();
        logic [31:0] frt;
        frt = pick(fwd_b, m_rt);
        chk("ex_valid", ex_valid, m_valid);
        chk("ex_reg_write", ex_reg_write, m_rw);
        chk("ex_alu_src", ex_alu_src, m_src);
        chk("ex_ctrl", ex_ctrl, m_ctrl);
        chk("ex_rs_addr", ex_rs_addr, m_rs_a);
        chk("ex_rt_addr", ex_rt_addr, m_rt_a);
        chk("ex_rd_addr", ex_rd_addr, m_rd_a);
        chk("ex_imm", ex_imm, m_imm);
        chk("alu_a", alu_a, pick(fwd_a, m_rs));
        chk("ex_store_data", ex_store_data, frt);
        chk("alu_b", alu_b, m_src ? m_imm : frt);
        chk("bubble_cnt", bubble_cnt, 64'(m_cnt));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_id(input logic v, input logic rw, input logic src, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [31:0] imm);
        id_valid = v; id_reg_write = rw; id_alu_src = src;
        id_rs_data = rs; id_rt_data = rt; id_imm = imm;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; fwd_a = 2'b00; fwd_b = 2'b00;
        mem_alu_result = 32'd0; wb_write_data = 32'd0; id_ctrl = 8'd0;
        id_rs_addr = 5'd0; id_rt_addr = 5'd0; id_rd_addr = 5'd0;
        set_id(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        model_reset();
        #12;
        check_all();
        @(negedge clk) rst = 1'b0;

        // Plain load, then the immediate path.
        set_id(1'b1, 1'b1, 1'b0, 32'h11, 32'h22, 32'h5);
        id_ctrl = 8'hA5; id_rs_addr = 5'd3; id_rt_addr = 5'd4; id_rd_addr = 5'd7;
        step();
        chk("load_alu_a", alu_a, 64'h11);
        chk("load_alu_b", alu_b, 64'h22);
        id_alu_src = 1'b1;
        step();
        chk("imm_alu_b", alu_b, 64'h5);
        id_alu_src = 1'b0;
        step();

        // Forward select priority (combinational, no edge).
        mem_alu_result = 32'hAA; wb_write_data = 32'hBB;
        fwd_a = 2'b10; #1 chk("fwd_a_mem", alu_a, 64'hAA);
        fwd_a = 2'b01; #1 chk("fwd_a_wb", alu_a, 64'hBB);
        fwd_a = 2'b11; #1 chk("fwd_a_11", alu_a, 64'h11);
        fwd_b = 2'b10; #1 chk("fwd_b_mem", ex_store_data, 64'hAA);
        chk("fwd_b_alu_b", alu_b, 64'hAA);
        fwd_b = 2'b00;

        // Stall refresh captures the WB value.
        fwd_a = 2'b01; stall = 1'b1;
        id_rd_addr = 5'd30; id_ctrl = 8'h0F; id_rs_data = 32'h99;
        step();
        stall = 1'b0; fwd_a = 2'b00; wb_write_data = 32'hCC; #1;
        chk("stall_alu_a", alu_a, 64'hBB);
        chk("stall_rd", ex_rd_addr, 64'd7);
        chk("stall_ctrl", ex_ctrl, 64'hA5);

        // Flush beats stall.
        stall = 1'b1; flush = 1'b1;
        step();
        chk("flush_valid", ex_valid, 64'd0);
        chk("flush_rw", ex_reg_write, 64'd0);
        chk("flush_rd", ex_rd_addr, 64'd0);
        chk("flush_cnt", bubble_cnt, 64'd1);
        stall = 1'b0; flush = 1'b0;

        // Asynchronous reset mid-cycle with a valid instruction held.
        set_id(1'b1, 1'b1, 1'b1, 32'h1234, 32'h5678, 32'h9);
        step();
        #3 rst = 1'b1;
        #1 model_reset();
        check_all();
        @(negedge clk) rst = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 9) == 0);
            set_id($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                   $urandom, $urandom, $urandom);
            id_ctrl = 8'($urandom);
            id_rs_addr = 5'($urandom); id_rt_addr = 5'($urandom); id_rd_addr = 5'($urandom);
            fwd_a = 2'($urandom); fwd_b = 2'($urandom);
            mem_alu_result = $urandom; wb_write_data = $urandom;
            #1 chk("rand_alu_a_pre", alu_a, pick(fwd_a, m_rs));
            step();
        end

        // Counter saturation from a fresh reset.
        rst = 1'b1; #1 model_reset();
        @(negedge clk) rst = 1'b0;
        stall = 1'b0; flush = 1'b1;
        repeat (65535) begin
            @(posedge clk);
            model_edge();
        end
        #1 chk("sat_preload", bubble_cnt, 64'hFFFF);
        step();
        chk("sat_hold", bubble_cnt, 64'hFFFF);
        flush = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
